// File: rtl/vn_vc_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vn_vc_requester_pkg
// Description : Shared injector definitions used by the VN x VC arbiter and
//               requester: lane count, index widths, lane-index formula and
//               the sticky error record.
// Revision    : 1.0 - initial release
// ============================================================================
package vn_vc_requester_pkg;

  // Ceiling log2, never below 1, so that a single-lane build still gets a
  // 1-bit lane index.
  function automatic int Log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Total number of VN x VC lanes (N).
  function automatic int num_lanes(input int num_vn, input int num_vc);
    return num_vn * num_vc;
  endfunction

  // Flattened lane index; the arbiter uses the same ordering.
  function automatic int lane_idx(input int vn, input int vc, input int num_vc);
    return vn * num_vc + vc;
  endfunction

  // Sticky error flags; packs to err[1:0] on the bus.
  typedef struct packed {
    logic credit_ovf;     // [1] credit returned to a full counter
    logic illegal_grant;  // [0] multi-hot grant or grant without request
  } err_t;

endpackage : vn_vc_requester_pkg
`default_nettype wire

// File: rtl/vn_vc_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : vn_vc_requester_if
// Description : Bundle of the requester's upstream, arbiter and downstream
//               signals.
//   in_valid  [N]            flit offered per lane
//   in_data   [N*FLIT_SIZE]  lane j at [j*FLIT_SIZE +: FLIT_SIZE]
//   in_ready  [N]            lane accepts a flit this cycle
//   req_out   [N]            request vector to the arbiter
//   grant_in  [N]            one-hot grant, same cycle as req_out
//   credit_in [N]            one downstream slot freed per pulse
//   flit_out  [FLIT_SIZE]    granted flit
//   flit_vld                 flit_out valid
//   flit_lane [BITS_N]       lane index of flit_out
//   err       [2]            sticky [0] illegal grant, [1] credit overflow
//   modport master : environment side (upstream, arbiter, downstream)
//   modport slave  : requester side
// Revision    : 1.0 - initial release
// ============================================================================
interface vn_vc_requester_if
  import vn_vc_requester_pkg::*;
#(
  parameter int NUM_VC    = 1,
  parameter int NUM_VN    = 3,
  parameter int FLIT_SIZE = 64
);
  localparam int N      = num_lanes(NUM_VN, NUM_VC);
  localparam int BITS_N = Log2(N);

  logic [N-1:0]           in_valid;
  logic [N*FLIT_SIZE-1:0] in_data;
  logic [N-1:0]           in_ready;
  logic [N-1:0]           req_out;
  logic [N-1:0]           grant_in;
  logic [N-1:0]           credit_in;
  logic [FLIT_SIZE-1:0]   flit_out;
  logic                   flit_vld;
  logic [BITS_N-1:0]      flit_lane;
  logic [1:0]             err;

  modport master (
    output in_valid, in_data, grant_in, credit_in,
    input  in_ready, req_out, flit_out, flit_vld, flit_lane, err
  );

  modport slave (
    input  in_valid, in_data, grant_in, credit_in,
    output in_ready, req_out, flit_out, flit_vld, flit_lane, err
  );

endinterface : vn_vc_requester_if
`default_nettype wire

// File: rtl/vn_vc_requester_onehot_enc_n.sv
`default_nettype none
// ============================================================================
// Module      : onehot_enc_n
// Description : N-bit one-hot to binary encoder with a legality flag.
//   onehot_i    [N]       one-hot (or all-zero) vector
//   bin_o       [BITS_N]  index of the set bit (0 when none set)
//   onehot_ok_o           high when at most one bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_enc_n
  import vn_vc_requester_pkg::*;
#(
  parameter int N      = 3,
  parameter int BITS_N = 2
) (
  input  logic [N-1:0]      onehot_i,
  output logic [BITS_N-1:0] bin_o,
  output logic              onehot_ok_o
);

  logic seen_w;

  // OR of the indices of all set bits; exact whenever the input is one-hot.
  // A second set bit after the first clears the ok flag.
  always_comb begin
    seen_w      = 1'b0;
    bin_o       = '0;
    onehot_ok_o = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        if (seen_w) onehot_ok_o = 1'b0;
        seen_w = 1'b1;
        bin_o  = bin_o | BITS_N'(i);
      end
    end
  end

endmodule : onehot_enc_n
`default_nettype wire

// File: rtl/vn_vc_requester.sv
`default_nettype none
// ============================================================================
// Module      : vn_vc_requester
// Description : Requester side of the VN x VC fixed-priority arbitration
//               handshake. Stages one head flit per lane, requests while the
//               lane holds a flit and has credit, emits the granted flit one
//               cycle after the grant and keeps one credit counter per lane.
//   clk    : rising-edge clock
//   rst_n  : asynchronous assert, synchronous release, active-low reset
//   bus    : vn_vc_requester_if.slave (handshake, grant, credit, flit out)
// Revision    : 1.0 - initial release
// ============================================================================
module vn_vc_requester
  import vn_vc_requester_pkg::*;
#(
  parameter int NUM_VC    = 1,
  parameter int NUM_VN    = 3,
  parameter int FLIT_SIZE = 64,
  parameter int CREDITS   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  vn_vc_requester_if.slave   bus
);

  localparam int N       = num_lanes(NUM_VN, NUM_VC);
  localparam int BITS_N  = Log2(N);
  localparam int BITS_CR = Log2(CREDITS + 1);
  localparam logic [BITS_CR-1:0] c_cred_full = BITS_CR'(CREDITS);

  logic [N-1:0]         req;
  logic [N-1:0]         acc;
  logic [N-1:0]         in_ready;
  logic [N-1:0]         cred_ovf;
  logic [FLIT_SIZE-1:0] hold_data [N];

  logic                 grant_onehot_ok;
  logic                 grant_legal;
  logic [BITS_N-1:0]    grant_bin;
  logic [FLIT_SIZE-1:0] flit_mux;

  logic                 flit_vld_q;
  logic [FLIT_SIZE-1:0] flit_out_q;
  logic [BITS_N-1:0]    flit_lane_q;
  err_t                 err_q, err_d;

  // --------------------------------------------------------------------------
  // Grant legality: at most one bit set, and only on requesting lanes. An
  // illegal grant is dropped as a whole. When legal, acc equals grant_in, so
  // the encoder output is also the binary index of the accepted lane.
  // --------------------------------------------------------------------------
  onehot_enc_n #(
    .N      (N),
    .BITS_N (BITS_N)
  ) u_grant_enc (
    .onehot_i    (bus.grant_in),
    .bin_o       (grant_bin),
    .onehot_ok_o (grant_onehot_ok)
  );

  assign grant_legal = grant_onehot_ok & ~(|(bus.grant_in & ~req));
  assign acc         = grant_legal ? (bus.grant_in & req) : '0;

  // --------------------------------------------------------------------------
  // Per-lane staging register and credit counter
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic                 hold_v_q, hold_v_d;
    logic [FLIT_SIZE-1:0] hold_data_q, hold_data_d;
    logic [BITS_CR-1:0]   cred_q, cred_d;
    logic                 ovf;

    // Request comes from registers only, so grant cannot loop back into it.
    assign req[j]       = hold_v_q & (cred_q != '0);
    // A granted lane may be refilled in the same cycle.
    assign in_ready[j]  = ~hold_v_q | acc[j];
    assign hold_data[j] = hold_data_q;
    assign cred_ovf[j]  = ovf;

    always_comb begin
      hold_v_d    = hold_v_q;
      hold_data_d = hold_data_q;
      if (bus.in_valid[j] && in_ready[j]) begin
        hold_v_d    = 1'b1;
        hold_data_d = bus.in_data[j*FLIT_SIZE +: FLIT_SIZE];
      end else if (acc[j]) begin
        hold_v_d    = 1'b0;
      end
    end

    // acc can only fire with a nonzero count, so the decrement never wraps.
    always_comb begin
      cred_d = cred_q;
      ovf    = 1'b0;
      case ({acc[j], bus.credit_in[j]})
        2'b10: cred_d = cred_q - BITS_CR'(1);
        2'b01: begin
          if (cred_q == c_cred_full) ovf    = 1'b1;
          else                       cred_d = cred_q + BITS_CR'(1);
        end
        default: cred_d = cred_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_v_q    <= 1'b0;
        hold_data_q <= '0;
        cred_q      <= c_cred_full;
      end else begin
        hold_v_q    <= hold_v_d;
        hold_data_q <= hold_data_d;
        cred_q      <= cred_d;
      end
    end
  end : g_lane

  // --------------------------------------------------------------------------
  // Output stage: AND-OR select of the accepted lane's held flit.
  // --------------------------------------------------------------------------
  always_comb begin
    flit_mux = '0;
    for (int j = 0; j < N; j++) begin
      if (acc[j]) flit_mux = flit_mux | hold_data[j];
    end
  end

  always_comb begin
    err_d = err_q;
    if (!grant_legal) err_d.illegal_grant = 1'b1;
    if (|cred_ovf)    err_d.credit_ovf    = 1'b1;
  end

  // flit_out/flit_lane keep their last value when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_vld_q  <= 1'b0;
      flit_out_q  <= '0;
      flit_lane_q <= '0;
      err_q       <= '0;
    end else begin
      flit_vld_q <= |acc;
      err_q      <= err_d;
      if (|acc) begin
        flit_out_q  <= flit_mux;
        flit_lane_q <= grant_bin;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.req_out   = req;
  assign bus.flit_out  = flit_out_q;
  assign bus.flit_vld  = flit_vld_q;
  assign bus.flit_lane = flit_lane_q;
  assign bus.err       = err_q;

endmodule : vn_vc_requester
`default_nettype wire
